// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem requests, output/skid buffer to decode.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module instr_fetch #(
  parameter int unsigned     WORD      = 64,
  parameter int unsigned     INSTR_LEN = 32,
  parameter logic [WORD-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic                 imem_ready,
  input  logic                 imem_rvalid,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  input  logic                 redirect_valid,
  input  logic [WORD-1:0]      redirect_base,
  input  logic [WORD-1:0]      redirect_offset,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [INSTR_LEN-1:0] instruction,
  output logic [WORD-1:0]      instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          fetch_count,
  output logic [31:0]          stall_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_e;

  localparam logic [WORD-1:0] PC_STEP = WORD'(4);

  state_e                 state_q, state_d;
  logic [WORD-1:0]        pc_q, pc_d;
  logic [WORD-1:0]        infl_pc_q, infl_pc_d;
  logic                   out_vld_q, out_vld_d;
  logic [INSTR_LEN-1:0]   out_instr_q, out_instr_d;
  logic [WORD-1:0]        out_pc_q, out_pc_d;
  logic [INSTR_LEN-1:0]   skid_instr_q, skid_instr_d;
  logic [WORD-1:0]        skid_pc_q, skid_pc_d;
  logic [WORD-1:0]        tgt_sum;
  logic [WORD-1:0]        tgt_pc;
  logic                   out_free;

  assign tgt_sum  = redirect_base + (redirect_offset << 2);
  assign tgt_pc   = {tgt_sum[WORD-1:2], 2'b00};
  assign out_free = !out_vld_q || instr_ready;

  // Request outputs are decoded purely from registered state, so they only change on clk.
  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = (state_q == S_REQ) ? pc_q : '0;
  assign instr_valid = out_vld_q;
  assign instruction = out_instr_q;
  assign instr_pc    = out_pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    infl_pc_d    = infl_pc_q;
    out_vld_d    = out_vld_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (out_vld_q && instr_ready) begin
      out_vld_d = 1'b0;
    end

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ready) begin
          infl_pc_d = pc_q;
          pc_d      = pc_q + PC_STEP;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (out_free) begin
            out_vld_d   = 1'b1;
            out_instr_d = imem_rdata;
            out_pc_d    = infl_pc_q;
            state_d     = S_REQ;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = infl_pc_q;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_free) begin
          out_vld_d   = 1'b1;
          out_instr_d = skid_instr_q;
          out_pc_d    = skid_pc_q;
          state_d     = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides everything; any response still owed by memory must be swallowed in DROP.
    if (redirect_valid) begin
      pc_d      = tgt_pc;
      out_vld_d = 1'b0;
      case (state_q)
        S_REQ:          state_d = imem_ready ? S_DROP : S_REQ;
        S_WAIT, S_DROP: state_d = imem_rvalid ? S_REQ : S_DROP;
        default:        state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      infl_pc_q    <= '0;
      out_vld_q    <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      infl_pc_q    <= infl_pc_d;
      out_vld_q    <= out_vld_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (out_vld_q && instr_ready && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (out_vld_q && !instr_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory responder, scoreboard monitor, directed and random stimulus.
module tb_instr_fetch;

  localparam int unsigned     WORD      = 64;
  localparam int unsigned     INSTR_LEN = 32;
  localparam logic [63:0]     RESET_PC  = 64'h0;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 imem_req;
  logic [WORD-1:0]      imem_addr;
  logic                 imem_ready;
  logic                 imem_rvalid;
  logic [INSTR_LEN-1:0] imem_rdata;
  logic                 redirect_valid;
  logic [WORD-1:0]      redirect_base;
  logic [WORD-1:0]      redirect_offset;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [INSTR_LEN-1:0] instruction;
  logic [WORD-1:0]      instr_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]          fetch_count;
  logic [31:0]          stall_count;
`endif

  instr_fetch #(.WORD(WORD), .INSTR_LEN(INSTR_LEN), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_base   (redirect_base),
    .redirect_offset (redirect_offset),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instruction     (instruction),
    .instr_pc        (instr_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count     (fetch_count),
    .stall_count     (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_deliv = 0;
  logic [63:0] exp_q[$];
  logic [63:0] acc_q[$];
  logic        pend = 1'b0;
  logic        mem_rand = 1'b0;
  int unsigned mem_delay = 1;
  logic [63:0] exp_addr;
  int unsigned m_fetch = 0;
  int unsigned m_stall = 0;

  // Memory contents are a fixed scramble of the word address.
  function automatic logic [31:0] memf(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [63:0] tgt(input logic [63:0] b, input logic [63:0] o);
    logic [63:0] t;
    t = b + o * 64'd4;
    t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_model();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(RESET_PC + 64'(4 * i));
  endtask

  task automatic flush_to(input logic [63:0] t);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(t + 64'(4 * i));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    reset_model();
  endtask

  // Drives the redirect for the coming edge and re-seeds the expected stream at the target.
  task automatic issue_redirect(input logic [63:0] b, input logic [63:0] o);
    redirect_valid  = 1'b1;
    redirect_base   = b;
    redirect_offset = o;
    flush_to(tgt(b, o));
  endtask

  // Memory responder: one outstanding request, configurable response delay.
  initial begin : mem_model
    logic        acc;
    logic [63:0] a;
    logic [63:0] pa;
    int unsigned cnt;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    exp_addr    = RESET_PC;
    cnt         = 0;
    pa          = '0;
    forever begin
      @(negedge clk);
      acc = rst_n && imem_req && imem_ready;
      a   = imem_addr;
      if (!rst_n) begin
        exp_addr = RESET_PC;
      end else begin
        if (acc) begin
          chk("req_addr", a, exp_addr);
          exp_addr = exp_addr + 64'd4;
        end
        if (redirect_valid) exp_addr = tgt(redirect_base, redirect_offset);
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (acc) begin
        pend = 1'b1;
        pa   = a;
        cnt  = mem_rand ? $urandom_range(1, 4) : mem_delay;
        acc_q.push_back(a);
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memf(pa);
          pend        = 1'b0;
        end
      end
      imem_ready = !pend && (!mem_rand || ($urandom_range(0, 3) != 0));
    end
  end

  // Monitor: sampled mid-cycle, describes what the next rising edge will do.
  initial begin : monitor
    logic        pv, pr, prd, preq, prdy;
    logic [63:0] ppc, paddr, e;
    logic [31:0] pins;
    pv = 0; pr = 0; prd = 0; preq = 0; prdy = 0;
    ppc = '0; paddr = '0; pins = '0; e = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0; preq = 0; m_fetch = 0; m_stall = 0;
        continue;
      end
      if (pv && !pr && !prd) begin
        chk("hold_valid", 64'(instr_valid), 64'd1);
        chk("hold_pc", instr_pc, ppc);
        chk("hold_instr", 64'(instruction), 64'(pins));
      end
      if (preq && !prdy && !prd) begin
        chk("req_hold", 64'(imem_req), 64'd1);
        chk("addr_hold", imem_addr, paddr);
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          chk("exp_queue_empty", 64'd0, 64'd1);
        end else begin
          e = exp_q.pop_front();
          exp_q.push_back(((exp_q.size() != 0) ? exp_q[$] : e) + 64'd4);
          chk("deliv_pc", instr_pc, e);
          chk("deliv_instr", 64'(instruction), 64'(memf(e)));
        end
        n_deliv++;
      end
      if (instr_valid && instr_ready && m_fetch != 32'hFFFF_FFFF) m_fetch++;
      if (instr_valid && !instr_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
      pv = instr_valid; pr = instr_ready; prd = redirect_valid;
      ppc = instr_pc; pins = instruction;
      preq = imem_req; prdy = imem_ready; paddr = imem_addr;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          d0;
    logic        hit;
    int          s;
    logic signed [63:0] so;
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_base   = '0;
    redirect_offset = '0;
    instr_ready     = 1'b0;
    reset_model();
    repeat (3) step();
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", imem_addr, 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instruction), 64'd0);
    chk("rst_pc", instr_pc, 64'd0);

    // Streaming
    rst_n = 1'b1;
    reset_model();
    acc_q.delete();
    instr_ready = 1'b1;
    for (int i = 0; i < 100 && acc_q.size() < 4; i++) step();
    chk("stream_timeout", 64'(acc_q.size() >= 4), 64'd1);
    if (acc_q.size() >= 4)
      for (int i = 0; i < 4; i++) chk("stream_addr", acc_q[i], 64'(4 * i));
    repeat (4) step();

    // Backpressure
    instr_ready = 1'b0;
    do_reset();
    acc_q.delete();
    for (int i = 0; i < 50 && !instr_valid; i++) step();
    chk("bp_first_valid", 64'(instr_valid), 64'd1);
    repeat (5) step();
    chk("bp_pc", instr_pc, 64'd0);
    chk("bp_no_req", 64'(imem_req), 64'd0);
    chk("bp_buffered", 64'(acc_q.size()), 64'd2);
    d0 = n_deliv;
    instr_ready = 1'b1;
    for (int i = 0; i < 50 && n_deliv < d0 + 3; i++) step();
    chk("bp_drain", 64'(n_deliv >= d0 + 3), 64'd1);

    // Redirect while WAIT
    do_reset();
    mem_delay = 4;
    for (int i = 0; i < 50 && !pend; i++) step();
    chk("rw_pending", 64'(pend), 64'd1);
    issue_redirect(64'h40, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    redirect_valid = 1'b0;
    acc_q.delete();
    for (int i = 0; i < 50 && acc_q.size() < 1; i++) step();
    chk("rw_req_timeout", 64'(acc_q.size() >= 1), 64'd1);
    if (acc_q.size() >= 1) chk("rw_addr", acc_q[0], 64'h38);
    for (int i = 0; i < 50 && !instr_valid; i++) step();
    chk("rw_valid", 64'(instr_valid), 64'd1);
    chk("rw_pc", instr_pc, 64'h38);

    // Redirect coinciding with a response and a handshake
    do_reset();
    mem_delay = 1;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      if (imem_rvalid && instr_valid) begin
        instr_ready = 1'b1;
        issue_redirect(64'h1000, 64'h10);
        hit = 1'b1;
      end else begin
        instr_ready = ($urandom_range(0, 1) == 1);
      end
      step();
    end
    chk("co_hit", 64'(hit), 64'd1);
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 50 && !instr_valid; i++) step();
    chk("co_valid", 64'(instr_valid), 64'd1);
    chk("co_pc", instr_pc, 64'h1040);

    // PC wrap
    do_reset();
    repeat (3) step();
    issue_redirect(64'hFFFF_FFFF_FFFF_FFF0, 64'd3);
    step();
    redirect_valid = 1'b0;
    acc_q.delete();
    for (int i = 0; i < 50 && acc_q.size() < 2; i++) step();
    chk("wrap_timeout", 64'(acc_q.size() >= 2), 64'd1);
    if (acc_q.size() >= 2) begin
      chk("wrap_addr0", acc_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_addr1", acc_q[1], 64'h0);
    end

    // Async reset mid-WAIT, stray response afterwards
    mem_delay = 4;
    for (int i = 0; i < 50 && !pend; i++) step();
    chk("ar_pending", 64'(pend), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_req", 64'(imem_req), 64'd0);
    chk("ar_addr", imem_addr, 64'd0);
    chk("ar_valid", 64'(instr_valid), 64'd0);
    chk("ar_instr", 64'(instruction), 64'd0);
    chk("ar_pc", instr_pc, 64'd0);
    step();
    rst_n = 1'b1;
    reset_model();
    acc_q.delete();
    for (int i = 0; i < 50 && acc_q.size() < 1; i++) step();
    chk("ar_req_timeout", 64'(acc_q.size() >= 1), 64'd1);
    if (acc_q.size() >= 1) chk("ar_first_addr", acc_q[0], RESET_PC);
    d0 = n_deliv;
    for (int i = 0; i < 50 && n_deliv < d0 + 2; i++) step();
    chk("ar_deliver", 64'(n_deliv >= d0 + 2), 64'd1);

    // Randomized traffic
    mem_rand = 1'b1;
    d0 = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      if (!redirect_valid && $urandom_range(0, 19) == 0) begin
        s  = int'($urandom_range(0, 127)) - 64;
        so = 64'(s);
        if ($urandom_range(0, 3) == 0) issue_redirect(64'hFFFF_FFFF_FFFF_FF00, so);
        else issue_redirect({$urandom, $urandom} & ~64'h3, so);
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;
    chk("rand_progress", 64'(n_deliv > d0 + 100), 64'd1);

`ifdef FETCH_PERF_CNT_EN
    mem_rand = 1'b0;
    mem_delay = 1;
    instr_ready = 1'b1;
    repeat (5) step();
    chk("perf_fetch", 64'(fetch_count), 64'(m_fetch));
    chk("perf_stall", 64'(stall_count), 64'(m_stall));
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    step();
    release dut.fetch_cnt_q;
    repeat (20) step();
    chk("perf_sat", 64'(fetch_count), 64'hFFFF_FFFF);
`endif

    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
